// File: rtl/line_fill_engine_if.sv
// Bundle of the miss, fill and driver-request signals around the line fill engine.
// The master view belongs to the engine and the slave view to the cache side and the driver side.
interface line_fill_engine_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int BEATS_PER_LINE = 4
);
  localparam int LINE_WIDTH = DATA_WIDTH * BEATS_PER_LINE;

  logic                    miss_valid;
  logic                    miss_ready;
  logic [ADDR_WIDTH-1:0]   miss_addr;
  logic                    miss_wb;
  logic [ADDR_WIDTH-1:0]   miss_wb_addr;
  logic [LINE_WIDTH-1:0]   miss_wb_line;

  logic                    fill_valid;
  logic                    fill_ready;
  logic [ADDR_WIDTH-1:0]   fill_addr;
  logic [LINE_WIDTH-1:0]   fill_line;

  logic                    drv_req_valid;
  logic                    drv_req_ready;
  logic                    drv_req_is_write;
  logic [ADDR_WIDTH-1:0]   drv_req_addr;
  logic [DATA_WIDTH-1:0]   drv_req_wdata;
  logic [DATA_WIDTH/8-1:0] drv_req_wstrb;
  logic                    drv_resp_valid;
  logic [DATA_WIDTH-1:0]   drv_resp_data;

  modport master (
    input  miss_valid, miss_addr, miss_wb, miss_wb_addr, miss_wb_line,
    input  fill_ready, drv_req_ready, drv_resp_valid, drv_resp_data,
    output miss_ready, fill_valid, fill_addr, fill_line,
    output drv_req_valid, drv_req_is_write, drv_req_addr, drv_req_wdata, drv_req_wstrb
  );

  modport slave (
    output miss_valid, miss_addr, miss_wb, miss_wb_addr, miss_wb_line,
    output fill_ready, drv_req_ready, drv_resp_valid, drv_resp_data,
    input  miss_ready, fill_valid, fill_addr, fill_line,
    input  drv_req_valid, drv_req_is_write, drv_req_addr, drv_req_wdata, drv_req_wstrb
  );
endinterface

// File: rtl/line_fill_engine.sv
// Cache miss handler: optional victim writeback, then a line fetch, issued as single-beat
// driver requests one at a time, with the assembled line handed back to the cache.
module line_fill_engine #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int BEATS_PER_LINE = 4
) (
  input  logic               clk,
  input  logic               rst,
  line_fill_engine_if.master bus,
  output logic               busy
);
  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int LINE_BYTES = BEAT_BYTES * BEATS_PER_LINE;
  localparam int LINE_WIDTH = DATA_WIDTH * BEATS_PER_LINE;
  localparam int CNT_W      = $clog2(BEATS_PER_LINE);
  localparam int BOFF_W     = $clog2(BEAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS_PER_LINE - 1);

  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT, FILL_OUT} state_t;

  state_t                 state, state_next;
  logic [CNT_W-1:0]       cnt, cnt_next;
  logic [ADDR_WIDTH-1:0]  line_base, wb_base;
  logic [LINE_WIDTH-1:0]  wb_line, fill_reg;
  logic [ADDR_WIDTH-1:0]  beat_offset;
  logic [DATA_WIDTH-1:0]  wb_beat;
  logic                   accept;
  logic                   store_beat;

  // Bases are line aligned, so OR-ing in the beat offset can never carry out of the line.
  assign beat_offset = ADDR_WIDTH'({cnt, {BOFF_W{1'b0}}});
  assign wb_beat     = wb_line[int'(cnt) * DATA_WIDTH +: DATA_WIDTH];
  assign accept      = bus.miss_valid && (state == IDLE);
  assign store_beat  = (state == RD_WAIT) && bus.drv_resp_valid;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // pre-edge values regardless of the order in which always blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      line_base <= '0;
      wb_base   <= '0;
      // NOTE: the line-wide data registers are reset as well, so a reset mid-fill
      // can never expose a partially assembled line on fill_line.
      wb_line   <= '0;
      fill_reg  <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        line_base <= bus.miss_addr & LINE_MASK;
        wb_base   <= bus.miss_wb_addr & LINE_MASK;
        wb_line   <= bus.miss_wb_line;
      end
      if (store_beat) begin
        fill_reg[int'(cnt) * DATA_WIDTH +: DATA_WIDTH] <= bus.drv_resp_data;
      end
    end
  end

  // NOTE: every signal written here gets a default first; a path that skipped one
  // would otherwise infer a latch.
  always_comb begin
    state_next           = state;
    cnt_next             = cnt;
    bus.miss_ready       = 1'b0;
    bus.fill_valid       = 1'b0;
    bus.drv_req_valid    = 1'b0;
    bus.drv_req_is_write = 1'b0;
    bus.drv_req_addr     = '0;
    bus.drv_req_wdata    = '0;
    bus.drv_req_wstrb    = '0;

    unique case (state)
      IDLE: begin
        bus.miss_ready = 1'b1;
        if (bus.miss_valid) begin
          state_next = bus.miss_wb ? WB_REQ : RD_REQ;
          cnt_next   = '0;
        end
      end
      WB_REQ: begin
        bus.drv_req_valid    = 1'b1;
        bus.drv_req_is_write = 1'b1;
        bus.drv_req_addr     = wb_base | beat_offset;
        bus.drv_req_wdata    = wb_beat;
        bus.drv_req_wstrb    = '1;
        if (bus.drv_req_ready) state_next = WB_WAIT;
      end
      WB_WAIT: begin
        if (bus.drv_resp_valid) begin
          if (cnt == LAST_BEAT) begin
            cnt_next   = '0;
            state_next = RD_REQ;
          end else begin
            cnt_next   = cnt + 1'b1;
            state_next = WB_REQ;
          end
        end
      end
      RD_REQ: begin
        bus.drv_req_valid = 1'b1;
        bus.drv_req_addr  = line_base | beat_offset;
        if (bus.drv_req_ready) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.drv_resp_valid) begin
          if (cnt == LAST_BEAT) begin
            state_next = FILL_OUT;
          end else begin
            cnt_next   = cnt + 1'b1;
            state_next = RD_REQ;
          end
        end
      end
      FILL_OUT: begin
        bus.fill_valid = 1'b1;
        if (bus.fill_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.fill_addr = line_base;
  assign bus.fill_line = fill_reg;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_line_fill_engine.sv
// Directed and randomized bench for line_fill_engine; a transaction-level model predicts
// the ordered driver request list and the filled line from the miss command alone.
module tb_line_fill_engine;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int BPL = 4;
  localparam int LW  = DW * BPL;
  localparam int BB  = DW / 8;
  localparam int LB  = BB * BPL;

  typedef struct {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [7:0]    wstrb;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  always #5 clk = ~clk;

  line_fill_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS_PER_LINE(BPL)) bus ();

  line_fill_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BEATS_PER_LINE(BPL)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  int          errors = 0;
  int          checks = 0;
  req_t        exp_q[$];
  logic [LW-1:0] last_fill = '0;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miss_ready"}, bus.miss_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_req_valid"}, bus.drv_req_valid, 0);
    check({tag, "_req_write"}, bus.drv_req_is_write, 0);
    check({tag, "_req_addr"}, bus.drv_req_addr, 0);
    check({tag, "_req_wdata"}, bus.drv_req_wdata, 0);
    check({tag, "_req_wstrb"}, bus.drv_req_wstrb, 0);
    check({tag, "_fill_valid"}, bus.fill_valid, 0);
    check({tag, "_fill_addr"}, bus.fill_addr, 0);
    check({tag, "_fill_line"}, bus.fill_line, 0);
  endtask

  // One miss transaction. dbase != 0 makes read data dbase+beat, otherwise random.
  // stall_k/spur_k/abort_k select the request index for a ready stall, a spurious
  // response, or a reset while waiting for that request's response (-1 = none).
  task automatic run_txn(input logic [AW-1:0] a, input logic wb, input logic [AW-1:0] wa,
                         input logic [LW-1:0] wl, input logic [DW-1:0] dbase,
                         input int stall_k, input int stall_len, input int fill_wait,
                         input int lat_max, input int spur_k, input int abort_k);
    logic [AW-1:0] lbase;
    logic [AW-1:0] wbase;
    logic [LW-1:0] exp_line;
    logic [DW-1:0] data;
    req_t          e;
    int            nreq;
    int            rd_idx;
    int            wait_c;
    int            lat;

    lbase    = a - (a % LB);
    wbase    = wa - (wa % LB);
    exp_line = '0;
    rd_idx   = 0;
    exp_q.delete();
    if (wb) for (int i = 0; i < BPL; i++) exp_q.push_back('{1'b1, wbase + AW'(i * BB), wl[i*DW +: DW], 8'hFF});
    for (int i = 0; i < BPL; i++) exp_q.push_back('{1'b0, lbase + AW'(i * BB), '0, 8'h00});
    nreq = exp_q.size();

    check("accept_ready", bus.miss_ready, 1);
    bus.miss_valid   = 1'b1;
    bus.miss_addr    = a;
    bus.miss_wb      = wb;
    bus.miss_wb_addr = wa;
    bus.miss_wb_line = wl;
    tick();
    bus.miss_valid   = 1'b0;
    bus.miss_addr    = $urandom;
    bus.miss_wb_addr = $urandom;
    bus.miss_wb_line = rand_line();

    for (int k = 0; k < nreq; k++) begin
      e = exp_q[k];
      wait_c = 0;
      while (!bus.drv_req_valid && wait_c < 20) begin
        tick();
        wait_c++;
      end
      check("req_latency", wait_c, 0);
      check("req_write", bus.drv_req_is_write, e.w);
      check("req_addr", bus.drv_req_addr, e.addr);
      check("req_wdata", bus.drv_req_wdata, e.wdata);
      check("req_wstrb", bus.drv_req_wstrb, e.wstrb);

      if (k == spur_k) begin
        bus.drv_resp_valid = 1'b1;
        bus.drv_resp_data  = {$urandom, $urandom};
        tick();
        bus.drv_resp_valid = 1'b0;
        check("spur_req_valid", bus.drv_req_valid, 1);
        check("spur_req_addr", bus.drv_req_addr, e.addr);
      end
      if (k == stall_k) begin
        for (int s = 0; s < stall_len; s++) begin
          tick();
          check("stall_valid", bus.drv_req_valid, 1);
          check("stall_addr", bus.drv_req_addr, e.addr);
          check("stall_wdata", bus.drv_req_wdata, e.wdata);
        end
      end

      bus.drv_req_ready = 1'b1;
      if (k == spur_k) begin
        bus.drv_resp_valid = 1'b1;
        bus.drv_resp_data  = {$urandom, $urandom};
      end
      tick();
      bus.drv_req_ready  = 1'b0;
      bus.drv_resp_valid = 1'b0;
      check("wait_valid_low", bus.drv_req_valid, 0);

      if (k == abort_k) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("abort_idle", busy, 0);
        return;
      end

      lat = $urandom_range(lat_max, 0);
      for (int l = 0; l < lat; l++) begin
        tick();
        check("wait_hold_low", bus.drv_req_valid, 0);
      end
      data = (dbase != 0) ? dbase + DW'(rd_idx) : {$urandom, $urandom};
      if (!e.w) begin
        exp_line[rd_idx*DW +: DW] = data;
        rd_idx++;
      end
      bus.drv_resp_valid = 1'b1;
      bus.drv_resp_data  = data;
      tick();
      bus.drv_resp_valid = 1'b0;
    end

    check("fill_latency", bus.fill_valid, 1);
    check("fill_addr", bus.fill_addr, lbase);
    check("fill_line", bus.fill_line, exp_line);
    for (int f = 0; f < fill_wait; f++) begin
      bus.miss_valid = 1'b1;
      bus.miss_wb    = 1'b0;
      tick();
      check("fill_hold_valid", bus.fill_valid, 1);
      check("fill_hold_line", bus.fill_line, exp_line);
      check("fill_hold_miss_ready", bus.miss_ready, 0);
    end
    bus.miss_valid = 1'b0;
    bus.fill_ready = 1'b1;
    tick();
    bus.fill_ready = 1'b0;
    check("post_fill_valid", bus.fill_valid, 0);
    check("post_fill_idle", busy, 0);
    check("post_fill_req", bus.drv_req_valid, 0);
    last_fill = exp_line;
  endtask

  initial begin
    rst                = 1'b1;
    bus.miss_valid     = 1'b0;
    bus.miss_addr      = '0;
    bus.miss_wb        = 1'b0;
    bus.miss_wb_addr   = '0;
    bus.miss_wb_line   = '0;
    bus.fill_ready     = 1'b0;
    bus.drv_req_ready  = 1'b0;
    bus.drv_resp_valid = 1'b1;
    bus.drv_resp_data  = 64'hDEAD_BEEF_0BAD_F00D;
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    bus.drv_resp_valid = 1'b0;
    check("stale_resp_idle", busy, 0);
    check("stale_resp_req", bus.drv_req_valid, 0);

    // Clean miss with known data.
    run_txn(32'h0000_1008, 1'b0, '0, '0, 64'hA0, -1, 0, 0, 0, -1, -1);
    check("clean_fill_const", bus.fill_line, {64'hA3, 64'hA2, 64'hA1, 64'hA0});

    // Dirty miss: writeback first, then fetch.
    run_txn(32'h0000_3000, 1'b1, 32'h0000_2000, {64'h44, 64'h33, 64'h22, 64'h11},
            0, -1, 0, 0, 0, -1, -1);

    // Ready stall on beat 2, then a long fill backpressure.
    run_txn(32'h0000_6010, 1'b1, 32'h0000_7000, rand_line(), 0, 2, 5, 0, 1, -1, -1);
    run_txn(32'h0000_8000, 1'b0, '0, '0, 0, -1, 0, 10, 1, -1, -1);

    // Spurious responses and fill_ready while idle, then in RD_REQ.
    bus.drv_resp_valid = 1'b1;
    bus.drv_resp_data  = {$urandom, $urandom};
    bus.fill_ready     = 1'b1;
    tick();
    tick();
    bus.drv_resp_valid = 1'b0;
    bus.fill_ready     = 1'b0;
    check("spur_idle_busy", busy, 0);
    check("spur_idle_fill_valid", bus.fill_valid, 0);
    check("spur_idle_fill_line", bus.fill_line, last_fill);
    run_txn(32'h0000_9000, 1'b0, '0, '0, 0, -1, 0, 0, 1, 1, -1);

    // Reset while waiting on read beat 1, then a fresh clean miss.
    run_txn(32'h0000_5000, 1'b0, '0, '0, 0, -1, 0, 0, 0, -1, 1);
    run_txn(32'h0000_4000, 1'b0, '0, '0, 0, -1, 0, 0, 0, -1, -1);

    // Lines at the top of the address space.
    run_txn(32'hFFFF_FFE8, 1'b1, 32'hFFFF_FFF0, rand_line(), 0, -1, 0, 0, 2, -1, -1);

    for (int t = 0; t < 10; t++) begin
      run_txn($urandom, 1'($urandom_range(1, 0)), $urandom, rand_line(), 0,
              int'($urandom_range(8, 0)), int'($urandom_range(3, 0)),
              int'($urandom_range(3, 0)), 3, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
